// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer
//
// Takes one decoded vector integer operation (one-hot resource vector,
// funct6, vl), checks that it is legal, and issues it to the vector ALU
// lanes as ceil(vl/LANES) element groups. Each group carries registered
// per-unit control vectors, a lane mask and the index of its first element.
// The multiplier and divider are paced by their latencies.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         operation request valid
//   req_ready_o         high only while idle
//   resource_vector_i   one-hot unit select
//   funct6_i            RVV funct6 opcode
//   vl_i                element count
//   grp_valid_o         group valid
//   grp_ready_i         downstream accepts the group
//   grp_index_o         index of the first element in the group
//   lane_mask_o         bit k = (grp_index_o + k < vl)
//   v*_ctrl_o           per-unit control vectors, zero for unselected units
//   done_o              one-cycle pulse when the operation completes
//   illegal_o           one-cycle pulse when a request is rejected
module vector_alu_sequencer #(
  parameter int LANES   = 4,
  parameter int VL_W    = 8,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [14:0]        resource_vector_i,
  input  logic [5:0]         funct6_i,
  input  logic [VL_W-1:0]    vl_i,
  output logic               grp_valid_o,
  input  logic               grp_ready_i,
  output logic [VL_W-1:0]    grp_index_o,
  output logic [LANES-1:0]   lane_mask_o,
  output logic [3:0]         vadd_ctrl_o,
  output logic [1:0]         vlog_ctrl_o,
  output logic [1:0]         vshft_ctrl_o,
  output logic [2:0]         vmul_ctrl_o,
  output logic [1:0]         vdiv_ctrl_o,
  output logic [1:0]         vmaxmin_ctrl_o,
  output logic               done_o,
  output logic               illegal_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Unit selects
  localparam logic [14:0] RV_VADD    = 15'h0001;
  localparam logic [14:0] RV_VLOG    = 15'h0004;
  localparam logic [14:0] RV_VSHFT   = 15'h0008;
  localparam logic [14:0] RV_VMAXMIN = 15'h0010;
  localparam logic [14:0] RV_VMUL    = 15'h0020;
  localparam logic [14:0] RV_VDIV    = 15'h0040;

  // RVV integer funct6 encodings (shared codes are named after every user)
  localparam logic [5:0] F_VADD             = 6'b000000;
  localparam logic [5:0] F_VSUB             = 6'b000010;
  localparam logic [5:0] F_VRSUB            = 6'b000011;
  localparam logic [5:0] F_VMINU            = 6'b000100;
  localparam logic [5:0] F_VMIN             = 6'b000101;
  localparam logic [5:0] F_VMAXU            = 6'b000110;
  localparam logic [5:0] F_VMAX             = 6'b000111;
  localparam logic [5:0] F_VAND             = 6'b001001;
  localparam logic [5:0] F_VOR              = 6'b001010;
  localparam logic [5:0] F_VXOR             = 6'b001011;
  localparam logic [5:0] F_VADC             = 6'b010000;
  localparam logic [5:0] F_VMADC            = 6'b010001;
  localparam logic [5:0] F_VSEXT_VZEXT_VSBC = 6'b010010;
  localparam logic [5:0] F_VMSBC            = 6'b010011;
  localparam logic [5:0] F_VDIVU            = 6'b100000;
  localparam logic [5:0] F_VDIV             = 6'b100001;
  localparam logic [5:0] F_VREMU            = 6'b100010;
  localparam logic [5:0] F_VREM             = 6'b100011;
  localparam logic [5:0] F_VMULHU           = 6'b100100;
  localparam logic [5:0] F_VSLL_VMUL        = 6'b100101;
  localparam logic [5:0] F_VMULHSU          = 6'b100110;
  localparam logic [5:0] F_VMULH            = 6'b100111;
  localparam logic [5:0] F_VSRL             = 6'b101000;
  localparam logic [5:0] F_VSRA_VMADD       = 6'b101001;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 2) : '0;
  localparam logic [VL_W:0]    STEP     = (VL_W+1)'(LANES);

  logic [1:0]       state_reg;
  logic [VL_W:0]    index_reg;
  logic [VL_W:0]    vl_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_mul_reg;
  logic             is_div_reg;
  logic             illegal_reg;
  logic [3:0]       vadd_reg;
  logic [1:0]       vlog_reg;
  logic [1:0]       vshft_reg;
  logic [2:0]       vmul_reg;
  logic [1:0]       vdiv_reg;
  logic [1:0]       vmaxmin_reg;

  // Decode of the incoming request
  logic       dec_illegal;
  logic       dec_mul;
  logic       dec_div;
  logic [3:0] dec_vadd;
  logic [1:0] dec_vlog;
  logic [1:0] dec_vshft;
  logic [2:0] dec_vmul;
  logic [1:0] dec_vdiv;
  logic [1:0] dec_vmaxmin;

  always_comb begin
    dec_illegal = 1'b1;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    dec_vadd    = '0;
    dec_vlog    = '0;
    dec_vshft   = '0;
    dec_vmul    = '0;
    dec_vdiv    = '0;
    dec_vmaxmin = '0;
    case (resource_vector_i)
      RV_VADD: begin
        dec_illegal = 1'b0;
        case (funct6_i)
          F_VADD:             dec_vadd = 4'b0000;
          F_VSUB:             dec_vadd = 4'b0010;
          F_VRSUB:            dec_vadd = 4'b0011;
          F_VADC:             dec_vadd = 4'b1000;
          F_VMADC:            dec_vadd = 4'b0100;
          F_VSEXT_VZEXT_VSBC: dec_vadd = 4'b1010;
          F_VMSBC:            dec_vadd = 4'b0110;
          default:            dec_illegal = 1'b1;
        endcase
      end
      RV_VLOG: begin
        dec_illegal = 1'b0;
        case (funct6_i)
          F_VAND:  dec_vlog = 2'b01;
          F_VOR:   dec_vlog = 2'b10;
          F_VXOR:  dec_vlog = 2'b11;
          default: dec_illegal = 1'b1;
        endcase
      end
      RV_VSHFT: begin
        dec_illegal = 1'b0;
        case (funct6_i)
          F_VSLL_VMUL:  dec_vshft = 2'b01;
          F_VSRL:       dec_vshft = 2'b10;
          F_VSRA_VMADD: dec_vshft = 2'b11;
          default:      dec_illegal = 1'b1;
        endcase
      end
      RV_VMUL: begin
        dec_illegal = 1'b0;
        dec_mul     = 1'b1;
        case (funct6_i)
          F_VSLL_VMUL: dec_vmul = 3'b011;
          F_VMULH:     dec_vmul = 3'b111;
          F_VMULHU:    dec_vmul = 3'b100;
          F_VMULHSU:   dec_vmul = 3'b101;
          default:     dec_illegal = 1'b1;
        endcase
      end
      RV_VDIV: begin
        dec_illegal = 1'b0;
        dec_div     = 1'b1;
        case (funct6_i)
          F_VDIVU: dec_vdiv = 2'b11;
          F_VDIV:  dec_vdiv = 2'b10;
          F_VREMU: dec_vdiv = 2'b01;
          F_VREM:  dec_vdiv = 2'b00;
          default: dec_illegal = 1'b1;
        endcase
      end
      RV_VMAXMIN: begin
        dec_illegal = 1'b0;
        case (funct6_i)
          F_VMINU: dec_vmaxmin = 2'b01;
          F_VMIN:  dec_vmaxmin = 2'b00;
          F_VMAXU: dec_vmaxmin = 2'b11;
          F_VMAX:  dec_vmaxmin = 2'b10;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // One bit wider than vl so the step past the last group cannot wrap
  logic [VL_W:0] next_index;
  logic          last_grp;
  logic          multi_cycle;
  assign next_index  = index_reg + STEP;
  assign last_grp    = (next_index >= vl_reg);
  assign multi_cycle = (is_mul_reg && (MUL_LAT > 1)) || (is_div_reg && (DIV_LAT > 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      vl_reg      <= '0;
      cnt_reg     <= '0;
      is_mul_reg  <= 1'b0;
      is_div_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      vadd_reg    <= '0;
      vlog_reg    <= '0;
      vshft_reg   <= '0;
      vmul_reg    <= '0;
      vdiv_reg    <= '0;
      vmaxmin_reg <= '0;
    end else begin
      illegal_reg <= 1'b0;
      // Set when the current group is finished (handshake or latency expired)
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            if (dec_illegal) begin
              illegal_reg <= 1'b1;
            end else if (vl_i == '0) begin
              state_reg <= DONE;
            end else begin
              index_reg   <= '0;
              vl_reg      <= {1'b0, vl_i};
              is_mul_reg  <= dec_mul;
              is_div_reg  <= dec_div;
              vadd_reg    <= dec_vadd;
              vlog_reg    <= dec_vlog;
              vshft_reg   <= dec_vshft;
              vmul_reg    <= dec_vmul;
              vdiv_reg    <= dec_vdiv;
              vmaxmin_reg <= dec_vmaxmin;
              state_reg   <= ISSUE;
            end
          end
        end
        ISSUE, BUSY: begin
          if ((state_reg == ISSUE) && grp_ready_i && multi_cycle) begin
            // BUSY runs latency-1 cycles after the issue cycle
            cnt_reg   <= is_mul_reg ? MUL_LOAD : DIV_LOAD;
            state_reg <= BUSY;
          end else if ((state_reg == BUSY) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if ((state_reg == BUSY) || grp_ready_i) begin
            if (last_grp) begin
              state_reg   <= DONE;
              index_reg   <= '0;
              is_mul_reg  <= 1'b0;
              is_div_reg  <= 1'b0;
              vadd_reg    <= '0;
              vlog_reg    <= '0;
              vshft_reg   <= '0;
              vmul_reg    <= '0;
              vdiv_reg    <= '0;
              vmaxmin_reg <= '0;
            end else begin
              index_reg <= next_index;
              state_reg <= ISSUE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Lane mask is only meaningful while a group is presented
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mask
      assign lane_mask_o[gi] = (state_reg == ISSUE) &&
                               ((index_reg + (VL_W+1)'(gi)) < vl_reg);
    end
  endgenerate

  assign req_ready_o    = (state_reg == IDLE);
  assign grp_valid_o    = (state_reg == ISSUE);
  assign done_o         = (state_reg == DONE);
  assign illegal_o      = illegal_reg;
  assign grp_index_o    = index_reg[VL_W-1:0];
  assign vadd_ctrl_o    = vadd_reg;
  assign vlog_ctrl_o    = vlog_reg;
  assign vshft_ctrl_o   = vshft_reg;
  assign vmul_ctrl_o    = vmul_reg;
  assign vdiv_ctrl_o    = vdiv_reg;
  assign vmaxmin_ctrl_o = vmaxmin_reg;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed testbench for vector_alu_sequencer (LANES=4, VL_W=8, MUL_LAT=3,
// DIV_LAT=8). Expected groups are queued when a request is driven and popped
// when the DUT hands them off.
module tb_vector_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [14:0] resource_vector_i = '0;
  logic [5:0]  funct6_i = '0;
  logic [7:0]  vl_i = '0;
  logic        grp_valid_o;
  logic        grp_ready_i = 1'b0;
  logic [7:0]  grp_index_o;
  logic [3:0]  lane_mask_o;
  logic [3:0]  vadd_ctrl_o;
  logic [1:0]  vlog_ctrl_o;
  logic [1:0]  vshft_ctrl_o;
  logic [2:0]  vmul_ctrl_o;
  logic [1:0]  vdiv_ctrl_o;
  logic [1:0]  vmaxmin_ctrl_o;
  logic        done_o;
  logic        illegal_o;

  vector_alu_sequencer #(.LANES(4), .VL_W(8), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resource_vector_i(resource_vector_i), .funct6_i(funct6_i), .vl_i(vl_i),
    .grp_valid_o(grp_valid_o), .grp_ready_i(grp_ready_i),
    .grp_index_o(grp_index_o), .lane_mask_o(lane_mask_o),
    .vadd_ctrl_o(vadd_ctrl_o), .vlog_ctrl_o(vlog_ctrl_o),
    .vshft_ctrl_o(vshft_ctrl_o), .vmul_ctrl_o(vmul_ctrl_o),
    .vdiv_ctrl_o(vdiv_ctrl_o), .vmaxmin_ctrl_o(vmaxmin_ctrl_o),
    .done_o(done_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // {vadd, vlog, vshft, vmul, vdiv, vmaxmin}
  logic [14:0] ctrl_vec;
  assign ctrl_vec = {vadd_ctrl_o, vlog_ctrl_o, vshft_ctrl_o, vmul_ctrl_o,
                     vdiv_ctrl_o, vmaxmin_ctrl_o};

  typedef struct packed {
    logic [7:0] idx;
    logic [3:0] mask;
    int         cyc;
  } grp_t;

  grp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request and follow it to done_o, comparing every presented
  // group against the queued expectation.
  task automatic run_op(input string name, input logic [14:0] res, input logic [5:0] f6,
                        input int vl, input logic [14:0] exp_ctrl, input int lat,
                        input int stall, input int exp_done);
    grp_t e;
    int   n;
    bit   seen_done;
    sb.delete();
    n = 0;
    for (int i = 0; i < vl; i += 4) begin
      e.idx = 8'(i);
      for (int k = 0; k < 4; k++) e.mask[k] = ((i + k) < vl);
      e.cyc = 1 + stall + n * lat;
      sb.push_back(e);
      n++;
    end
    @(negedge clk_i);
    chk({name, "_ready_before"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    resource_vector_i = res;
    funct6_i = f6;
    vl_i = 8'(vl);
    seen_done = 1'b0;
    for (int c = 1; c <= 100 && !seen_done; c++) begin
      @(negedge clk_i);
      if (c == 1) req_valid_i = 1'b0;
      grp_ready_i = (c > stall);
      if (grp_valid_o) begin
        if (sb.size() == 0) begin
          chk({name, "_unexpected_grp"}, 32'(grp_valid_o), 32'd0);
        end else begin
          e = sb[0];
          chk({name, "_idx"}, 32'(grp_index_o), 32'(e.idx));
          chk({name, "_mask"}, 32'(lane_mask_o), 32'(e.mask));
          chk({name, "_ctrl"}, 32'(ctrl_vec), 32'(exp_ctrl));
          if (grp_ready_i) begin
            chk({name, "_grp_cycle"}, 32'(c), 32'(e.cyc));
            $display("grp %s cycle=%0d idx=%0d mask=%b ctrl=%h", name, c,
                     grp_index_o, lane_mask_o, ctrl_vec);
            void'(sb.pop_front());
          end
        end
      end
      if (done_o) begin
        seen_done = 1'b1;
        chk({name, "_done_cycle"}, 32'(c), 32'(exp_done));
        chk({name, "_groups_left"}, 32'(sb.size()), 32'd0);
        chk({name, "_ctrl_at_done"}, 32'(ctrl_vec), 32'd0);
        $display("op %s done at cycle %0d", name, c);
      end
    end
    if (!seen_done) chk({name, "_done_timeout"}, 32'(done_o), 32'd1);
    grp_ready_i = 1'b0;
    @(negedge clk_i);
    chk({name, "_ready_after"}, 32'(req_ready_o), 32'd1);
  endtask

  // Requests that complete without any group: check the T+1 pulses.
  task automatic run_reject(input string name, input logic [14:0] res, input logic [5:0] f6,
                            input int vl, input logic exp_ill, input logic exp_done);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    resource_vector_i = res;
    funct6_i = f6;
    vl_i = 8'(vl);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk({name, "_illegal"}, 32'(illegal_o), 32'(exp_ill));
    chk({name, "_done"}, 32'(done_o), 32'(exp_done));
    chk({name, "_grp_valid"}, 32'(grp_valid_o), 32'd0);
    chk({name, "_ready_t1"}, 32'(req_ready_o), 32'(exp_ill));
    $display("reject %s illegal=%b done=%b", name, illegal_o, done_o);
    @(negedge clk_i);
    chk({name, "_pulse_end"}, 32'({illegal_o, done_o, grp_valid_o}), 32'd0);
    chk({name, "_ready_t2"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    // Reset values
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_outputs", 32'({grp_valid_o, done_o, illegal_o, grp_index_o, lane_mask_o, ctrl_vec}), 32'd0);
    rst_i = 1'b0;

    run_op("vadd_vl10",  15'h0001, 6'b000000, 10, 15'h0000, 1, 0, 4);
    run_op("vsub_stall", 15'h0001, 6'b000010, 4,  {4'b0010, 11'b0}, 1, 3, 5);
    run_op("vmulh_vl8",  15'h0020, 6'b100111, 8,  {8'b0, 3'b111, 4'b0}, 3, 0, 7);
    run_op("vdiv_vl3",   15'h0040, 6'b100001, 3,  {11'b0, 2'b10, 2'b00}, 8, 0, 9);
    run_op("vsra_vl6",   15'h0008, 6'b101001, 6,  {6'b0, 2'b11, 7'b0}, 1, 0, 3);
    run_op("vmaxu_vl4",  15'h0010, 6'b000110, 4,  {13'b0, 2'b11}, 1, 0, 2);

    run_reject("bad_resource", 15'h0080, 6'b000000, 5, 1'b1, 1'b0);
    run_reject("vlog_vadd",    15'h0004, 6'b000000, 5, 1'b1, 1'b0);
    run_reject("vadd_vl0",     15'h0001, 6'b000000, 0, 1'b0, 1'b1);

    // Reset during the second BUSY cycle of a vdiv
    @(negedge clk_i);
    req_valid_i = 1'b1;
    resource_vector_i = 15'h0040;
    funct6_i = 6'b100001;
    vl_i = 8'd8;
    grp_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("rstop_grp_valid", 32'(grp_valid_o), 32'd1);
    @(negedge clk_i);
    chk("rstop_busy1", 32'(grp_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rstop_ready", 32'(req_ready_o), 32'd1);
    chk("rstop_outputs", 32'({grp_valid_o, done_o, illegal_o, grp_index_o, lane_mask_o, ctrl_vec}), 32'd0);
    $display("reset applied mid-operation");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      chk("rstop_quiet", 32'({done_o, grp_valid_o, req_ready_o}), 32'b001);
    end
    grp_ready_i = 1'b0;

    run_op("vand_vl5", 15'h0004, 6'b001001, 5, {4'b0, 2'b01, 9'b0}, 1, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_alu_sequencer.md
# vector_alu_sequencer

Parametrised successor to the combinational vector ALU control decode. Accepts one decoded vector integer operation (resource vector, funct6, vl), validates it, and issues it to the vector ALU datapath as a sequence of LANES-wide element groups. Each group carries registered per-unit control vectors, a lane mask and the element index, and multi-cycle units (multiplier, divider) are paced by their latency. The block sits between the vector issue stage and the vector ALU lanes.

## Interface
- LANES, 4: elements processed per group (power of two, ≥1).
- VL_W, 8: width of vl; maximum vl = 2^VL_W−1.
- MUL_LAT, 3: cycles per group for the vmul unit (≥1).
- DIV_LAT, 8: cycles per group for the vdiv unit (≥1).

- clk_i  in  1  clock; everything is sampled on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  operation request valid.
- req_ready_o  out  1  high only in IDLE.
- resource_vector_i  in  15  one-hot unit select: vadd 15'h0001, vlog 15'h0004, vshft 15'h0008, vmaxmin 15'h0010, vmul 15'h0020, vdiv 15'h0040.
- funct6_i  in  6  opcode, encoded with the riscv_vector_integer.vh macros.
- vl_i  in  VL_W  element count.
- grp_valid_o  out  1  group valid.
- grp_ready_i  in  1  downstream accepts the group.
- grp_index_o  out  VL_W  index of the first element in the group.
- lane_mask_o  out  LANES  bit k = (grp_index_o + k < vl).
- vadd_ctrl_o  out  4  {with_carry_borrow, compute_carry, add_sub, reverse}.
- vlog_ctrl_o  out  2  01 AND, 10 OR, 11 XOR.
- vshft_ctrl_o  out  2  01 SLL, 10 SRL, 11 SRA.
- vmul_ctrl_o  out  3  {vd_high_low, vs1_signed, vs2_signed}.
- vdiv_ctrl_o  out  2  {remainder_division, signed_unsigned}.
- vmaxmin_ctrl_o  out  2  {maximum_minimum, signed_unsigned}.
- done_o  out  1  one-cycle pulse when the operation completes.
- illegal_o  out  1  one-cycle pulse when a request is rejected.

## Operation
- Decode, captured into registers at request acceptance:
  - vadd unit: vadd 0000, vsub 0010, vrsub 0011, vadc 1000, vmadc 0100, vsext_vzext_vsbc 1010, vmsbc 0110.
  - vlog unit: vand 01, vor 10, vxor 11.
  - vshft unit: vsll_vmul 01, vsrl 10, vsra_vmadd 11.
  - vmul unit: vmul 011, vmulh 111, vmulhu 100, vmulhsu 101.
  - vdiv unit: vdivu 11, vdiv 10, vremu 01, vrem 00.
  - vmaxmin unit: vminu 01, vmin 00, vmaxu 11, vmax 10.
  - All control outputs of the unselected units are 0.
- Illegal requests:
  - A resource vector not in the six listed values is illegal.
  - A funct6 not listed for the selected unit is illegal.
  - This differs from the previous decoder, which output zeros for these cases.
- FSM states: IDLE, ISSUE, BUSY, DONE.
  - IDLE: on req_valid_i & req_ready_o:
    - illegal request → illegal_o=1 next cycle, remain in IDLE.
    - vl_i==0 → go to DONE.
    - otherwise capture controls, set index=0, go to ISSUE.
  - ISSUE: grp_valid_o=1; index, mask and controls are held stable until grp_ready_i. On the handshake:
    - if the unit latency > 1 → BUSY, with a counter loaded to latency−2.
    - otherwise advance.
  - BUSY: grp_valid_o=0; the counter decrements each cycle; advance when the counter reaches 0.
  - Advance: if index+LANES ≥ vl → DONE; else index += LANES and go to ISSUE.
  - DONE: done_o=1 for one cycle, all control outputs cleared, go to IDLE.
- Latency: vadd, vlog, vshft and vmaxmin are 1 cycle; vmul is MUL_LAT; vdiv is DIV_LAT.
- Index and compare arithmetic use VL_W+1 bits so that index+LANES never wraps. grp_index_o is the low VL_W bits.
- Number of groups = ceil(vl/LANES). lane_mask_o is all ones except in the final partial group.

## Timing
- Reset values: state IDLE; every output 0 except req_ready_o=1.
- Reset mid-operation aborts the operation immediately. No done_o is produced and no further groups are issued.
- Request accepted in cycle T → first grp_valid_o at T+1.
- 1-cycle unit with grp_ready_i held high: groups at T+1..T+G, done_o at T+G+1, req_ready_o high at T+G+2.
- Multi-cycle unit: group n is issued at T+1+n·LAT. done_o follows the final BUSY period.
- illegal_o and the vl=0 done_o pulse are both at T+1; req_ready_o is high again at T+1 (illegal case) or T+2 (vl=0 case).
- Outputs never change while grp_valid_o=1 and grp_ready_i=0.

## Test plan
- vadd, vl=10, grp_ready_i=1 → groups at index 0/4/8 with masks 1111/1111/0011, vadd_ctrl_o=0000; done_o at T+4.
- vsub, vl=4, grp_ready_i low for 3 cycles → grp_valid_o, index 0, mask 1111 and vadd_ctrl_o=0010 held stable; done_o one cycle after the handshake.
- vmulh, vl=8, MUL_LAT=3 → groups at T+1 and T+4 with vmul_ctrl_o=111; done_o at T+7; other control vectors stay 0.
- vdiv, vl=3, DIV_LAT=8 → single group with mask 0111 and vdiv_ctrl_o=10; done_o at T+9.
- Three rejected/empty requests, each checked at T+1:
  - resource 15'h0080 → illegal_o only.
  - vlog unit with funct6=vadd → illegal_o only.
  - vadd with vl=0 → done_o only.
  - In all three cases grp_valid_o stays 0.
- rst_i asserted during the second vdiv BUSY cycle → outputs reset immediately; no done_o; req_ready_o=1 after reset; the next request is processed normally.
